// File: rtl/gearbox_pkg.sv
// gearbox_pkg: default 64b/66b width constants and the cadence/width helper
// functions shared by the gearbox sequencer and the gearbox datapaths.
package gearbox_pkg;

    // Default 64b/66b geometry: 32-bit datapath, 64-bit payload, 2-bit header.
    localparam int GB_DATA_WIDTH  = 32;
    localparam int GB_BLOCK_WIDTH = 64;
    localparam int GB_HDR_WIDTH   = 2;

    // Datapath words per block.
    function automatic int gb_step_div(input int data_width, input int block_width);
        return block_width / data_width;
    endfunction

    // Blocks per sequence before the header bits add up to a whole block.
    function automatic int gb_max_val(input int block_width, input int hdr_width);
        return block_width / hdr_width;
    endfunction

    // Width of the block counter (holds 0..max_val).
    function automatic int gb_cw(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    // Width of the word phase; at least one bit even when a block is one word.
    function automatic int gb_pw(input int step_div);
        return (step_div <= 1) ? 1 : $clog2(step_div);
    endfunction

    // Width of the accumulated header-bit offset (holds 0..block_width).
    function automatic int gb_ow(input int block_width);
        return $clog2(block_width + 1);
    endfunction

endpackage

// File: rtl/gearbox_slip_ctl.sv
// gearbox_slip_ctl: RX alignment slip qualifier. Accepts a slip request only
// when enabled, not loading, not in pause and outside the holdoff window,
// then blocks further slips for SLIP_HOLDOFF enabled cycles.
module gearbox_slip_ctl
#(
    parameter int  SLIP_HOLDOFF = 4,
    localparam int HW           = $clog2(SLIP_HOLDOFF + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic load,
    input  logic slip,
    input  logic pause,
    output logic accept,
    output logic slip_ack
);

    logic [HW-1:0] holdoff;

    // Accepted slip freezes the sequencer for this cycle (combinational into
    // the sequencer's next-state logic only, never to an output).
    assign accept = slip && en && !load && !pause && (holdoff == '0);

    // Holdoff window and registered acknowledge; load clears the window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            holdoff  <= '0;
            slip_ack <= 1'b0;
        end else begin
            slip_ack <= accept;
            if (load)
                holdoff <= '0;
            else if (accept)
                holdoff <= HW'(SLIP_HOLDOFF);
            else if (en && (holdoff != '0))
                holdoff <= holdoff - 1'b1;
        end
    end

endmodule

// File: rtl/gearbox_phase_seq.sv
// gearbox_phase_seq: word-phase / block-count sequencer for 64b/66b-style
// gearboxes. Cadence derives from DATA_WIDTH, BLOCK_WIDTH and HDR_WIDTH.
// Optional RX alignment slip with holdoff is built when GEARBOX_SEQ_SLIP_EN
// is defined; otherwise the slip/slip_ack ports do not exist.
module gearbox_phase_seq
    import gearbox_pkg::*;
#(
    parameter int  DATA_WIDTH   = GB_DATA_WIDTH,
    parameter int  BLOCK_WIDTH  = GB_BLOCK_WIDTH,
    parameter int  HDR_WIDTH    = GB_HDR_WIDTH,
    parameter int  SLIP_HOLDOFF = 4,
    localparam int STEP_DIV     = gb_step_div(DATA_WIDTH, BLOCK_WIDTH),
    localparam int MAX_VAL      = gb_max_val(BLOCK_WIDTH, HDR_WIDTH),
    localparam int CW           = gb_cw(MAX_VAL),
    localparam int PW           = gb_pw(STEP_DIV),
    localparam int OW           = gb_ow(BLOCK_WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          load,
    input  logic [CW-1:0] load_count,
`ifdef GEARBOX_SEQ_SLIP_EN
    input  logic          slip,
    output logic          slip_ack,
`endif
    output logic [CW-1:0] count,
    output logic [PW-1:0] phase,
    output logic          pause,
    output logic          hdr_valid,
    output logic [OW-1:0] bit_offset
);

    // Reject geometries the gearbox cannot sequence.
    if ((DATA_WIDTH < 1) || (HDR_WIDTH < 1) ||
        (BLOCK_WIDTH % DATA_WIDTH != 0) || (BLOCK_WIDTH % HDR_WIDTH != 0) ||
        (SLIP_HOLDOFF < 1)) begin : g_bad_cfg
        $error("gearbox_phase_seq: illegal DATA/BLOCK/HDR width or SLIP_HOLDOFF");
    end

    localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_VAL);
    localparam logic [PW-1:0] LAST_WORD = PW'(STEP_DIV - 1);

    logic          hold;
    logic [CW-1:0] load_sat;

    assign load_sat = (load_count > MAX_CNT) ? MAX_CNT : load_count;

`ifdef GEARBOX_SEQ_SLIP_EN
    gearbox_slip_ctl #(
        .SLIP_HOLDOFF (SLIP_HOLDOFF)
    ) u_slip_ctl (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .slip     (slip),
        .pause    (pause),
        .accept   (hold),
        .slip_ack (slip_ack)
    );
`else
    assign hold = 1'b0;
`endif

    // Load wins over everything; otherwise step phase, bump count on the last word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            phase <= '0;
        end else if (load) begin
            count <= load_sat;
            phase <= '0;
        end else if (en && !hold) begin
            if (phase == LAST_WORD) begin
                phase <= '0;
                count <= (count == MAX_CNT) ? '0 : count + 1'b1;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

    // Decodes come only from the count/phase registers.
    assign pause      = (count == MAX_CNT);
    assign hdr_valid  = (phase == '0) && !pause;
    assign bit_offset = OW'(count) * OW'(HDR_WIDTH);

endmodule

// File: tb/tb_gearbox_phase_seq.sv
// tb_gearbox_phase_seq: directed checks of the gearbox sequencer with the
// default geometry plus 64-bit and 16-bit datapath variants.
module tb_gearbox_phase_seq;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic [5:0] load_count;
    logic       ld_aux;
    logic [5:0] lc_aux;

    logic [5:0] cnt_m, cnt_a, cnt_b;
    logic [0:0] ph_m, ph_a;
    logic [1:0] ph_b;
    logic       ps_m, ps_a, ps_b;
    logic       hv_m, hv_a, hv_b;
    logic [6:0] off_m, off_a, off_b;

`ifdef GEARBOX_SEQ_SLIP_EN
    logic slip;
    logic ack_m, ack_a, ack_b;
`endif

    int errors = 0;
    int checks = 0;
    logic [16:0] got, exp;

    gearbox_phase_seq u_dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_count(load_count),
`ifdef GEARBOX_SEQ_SLIP_EN
        .slip(slip), .slip_ack(ack_m),
`endif
        .count(cnt_m), .phase(ph_m), .pause(ps_m), .hdr_valid(hv_m), .bit_offset(off_m)
    );

    gearbox_phase_seq #(.DATA_WIDTH(64)) u_w64 (
        .clk(clk), .reset(reset), .en(en), .load(ld_aux), .load_count(lc_aux),
`ifdef GEARBOX_SEQ_SLIP_EN
        .slip(1'b0), .slip_ack(ack_a),
`endif
        .count(cnt_a), .phase(ph_a), .pause(ps_a), .hdr_valid(hv_a), .bit_offset(off_a)
    );

    gearbox_phase_seq #(.DATA_WIDTH(16)) u_w16 (
        .clk(clk), .reset(reset), .en(en), .load(ld_aux), .load_count(lc_aux),
`ifdef GEARBOX_SEQ_SLIP_EN
        .slip(1'b0), .slip_ack(ack_b),
`endif
        .count(cnt_b), .phase(ph_b), .pause(ps_b), .hdr_valid(hv_b), .bit_offset(off_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {count, phase, pause, hdr_valid, bit_offset} for block c, word p
    // (MAX_VAL = 32, HDR_WIDTH = 2 for every instance here).
    function automatic logic [16:0] st(input int c, input int p);
        logic pz;
        pz = (c == 32);
        return {6'(c), 2'(p), pz, (p == 0) && !pz, 7'(c * 2)};
    endfunction

    task automatic test_reset;
        reset = 1'b0; en = 1'b0; load = 1'b0;
        repeat (2) @(negedge clk);
        checks++; got = {cnt_m, 1'b0, ph_m, ps_m, hv_m, off_m}; exp = st(0, 0);
        if (got !== exp) begin errors++; $display("FAIL reset_main got=%h exp=%h", got, exp); end
        checks++; got = {cnt_a, 1'b0, ph_a, ps_a, hv_a, off_a};
        if (got !== exp) begin errors++; $display("FAIL reset_w64 got=%h exp=%h", got, exp); end
        checks++; got = {cnt_b, ph_b, ps_b, hv_b, off_b};
        if (got !== exp) begin errors++; $display("FAIL reset_w16 got=%h exp=%h", got, exp); end
`ifdef GEARBOX_SEQ_SLIP_EN
        checks++;
        if (ack_m !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", ack_m); end
`endif
    endtask

    // 132 enabled cycles: two full default sequences; w64/w16 alongside.
    task automatic test_free_run;
        reset = 1'b1; en = 1'b1;
        for (int k = 0; k < 132; k++) begin
            checks++; got = {cnt_m, 1'b0, ph_m, ps_m, hv_m, off_m}; exp = st((k / 2) % 33, k % 2);
            if (got !== exp) begin errors++; $display("FAIL free_run_main k=%0d got=%h exp=%h", k, got, exp); end
            checks++; got = {cnt_a, 1'b0, ph_a, ps_a, hv_a, off_a}; exp = st(k % 33, 0);
            if (got !== exp) begin errors++; $display("FAIL free_run_w64 k=%0d got=%h exp=%h", k, got, exp); end
            checks++; got = {cnt_b, ph_b, ps_b, hv_b, off_b}; exp = st((k / 4) % 33, k % 4);
            if (got !== exp) begin errors++; $display("FAIL free_run_w16 k=%0d got=%h exp=%h", k, got, exp); end
            @(negedge clk);
        end
    endtask

    // en toggles each cycle: same sequence at half rate, frozen while en=0.
    task automatic test_enable_toggle;
        for (int i = 0; i < 40; i++) begin
            int kk;
            kk = (i + 1) / 2;
            checks++; got = {cnt_m, 1'b0, ph_m, ps_m, hv_m, off_m}; exp = st(kk / 2, kk % 2);
            if (got !== exp) begin errors++; $display("FAIL en_toggle_main i=%0d got=%h exp=%h", i, got, exp); end
            checks++; got = {cnt_b, ph_b, ps_b, hv_b, off_b}; exp = st(kk / 4, kk % 4);
            if (got !== exp) begin errors++; $display("FAIL en_toggle_w16 i=%0d got=%h exp=%h", i, got, exp); end
            en = (i % 2 == 0);
            @(negedge clk);
        end
    endtask

    task automatic test_load;
        load = 1'b1; load_count = 6'd5; en = 1'b1;
        @(negedge clk);
        checks++; got = {cnt_m, 1'b0, ph_m, ps_m, hv_m, off_m}; exp = st(5, 0);
        if (got !== exp) begin errors++; $display("FAIL load5 got=%h exp=%h", got, exp); end
        load = 1'b0;
        @(negedge clk);
        checks++; got = {cnt_m, 1'b0, ph_m, ps_m, hv_m, off_m}; exp = st(5, 1);
        if (got !== exp) begin errors++; $display("FAIL load5_adv got=%h exp=%h", got, exp); end
        load = 1'b1; load_count = 6'd40;
`ifdef GEARBOX_SEQ_SLIP_EN
        slip = 1'b1;
`endif
        @(negedge clk);
        checks++; got = {cnt_m, 1'b0, ph_m, ps_m, hv_m, off_m}; exp = st(32, 0);
        if (got !== exp) begin errors++; $display("FAIL load40_sat got=%h exp=%h", got, exp); end
`ifdef GEARBOX_SEQ_SLIP_EN
        checks++;
        if (ack_m !== 1'b0) begin errors++; $display("FAIL load_cancels_slip got=%b exp=0", ack_m); end
        slip = 1'b0;
`endif
        load = 1'b0;
        @(negedge clk);
        checks++; got = {cnt_m, 1'b0, ph_m, ps_m, hv_m, off_m}; exp = st(32, 1);
        if (got !== exp) begin errors++; $display("FAIL pause_word1 got=%h exp=%h", got, exp); end
        @(negedge clk);
        checks++; got = {cnt_m, 1'b0, ph_m, ps_m, hv_m, off_m}; exp = st(0, 0);
        if (got !== exp) begin errors++; $display("FAIL wrap got=%h exp=%h", got, exp); end
        en = 1'b0; load = 1'b1; load_count = 6'd7;
        @(negedge clk);
        checks++; got = {cnt_m, 1'b0, ph_m, ps_m, hv_m, off_m}; exp = st(7, 0);
        if (got !== exp) begin errors++; $display("FAIL load_en0 got=%h exp=%h", got, exp); end
        load_count = 6'd63;
        @(negedge clk);
        checks++; got = {cnt_m, 1'b0, ph_m, ps_m, hv_m, off_m}; exp = st(32, 0);
        if (got !== exp) begin errors++; $display("FAIL load63_sat got=%h exp=%h", got, exp); end
        load = 1'b0;
        repeat (2) @(negedge clk);
        checks++; got = {cnt_m, 1'b0, ph_m, ps_m, hv_m, off_m};
        if (got !== exp) begin errors++; $display("FAIL hold_en0 got=%h exp=%h", got, exp); end
    endtask

`ifdef GEARBOX_SEQ_SLIP_EN
    task automatic test_slip;
        load = 1'b1; load_count = 6'd3; en = 1'b1;
        @(negedge clk);
        load = 1'b0; slip = 1'b1;
        @(negedge clk);
        checks++; got = {cnt_m, 1'b0, ph_m, ps_m, hv_m, off_m}; exp = st(3, 0);
        if (got !== exp || ack_m !== 1'b1) begin errors++; $display("FAIL slip_accept got=%h ack=%b exp=%h ack=1", got, ack_m, exp); end
        slip = 1'b0;
        @(negedge clk);
        checks++; got = {cnt_m, 1'b0, ph_m, ps_m, hv_m, off_m}; exp = st(3, 1);
        if (got !== exp || ack_m !== 1'b0) begin errors++; $display("FAIL slip_resume got=%h ack=%b exp=%h ack=0", got, ack_m, exp); end
        slip = 1'b1;
        @(negedge clk);
        checks++; got = {cnt_m, 1'b0, ph_m, ps_m, hv_m, off_m}; exp = st(4, 0);
        if (got !== exp || ack_m !== 1'b0) begin errors++; $display("FAIL slip_holdoff got=%h ack=%b exp=%h ack=0", got, ack_m, exp); end
        slip = 1'b0; load = 1'b1; load_count = 6'd32;
        @(negedge clk);
        load = 1'b0; slip = 1'b1;
        @(negedge clk);
        checks++; got = {cnt_m, 1'b0, ph_m, ps_m, hv_m, off_m}; exp = st(32, 1);
        if (got !== exp || ack_m !== 1'b0) begin errors++; $display("FAIL slip_pause got=%h ack=%b exp=%h ack=0", got, ack_m, exp); end
        @(negedge clk);
        checks++; got = {cnt_m, 1'b0, ph_m, ps_m, hv_m, off_m}; exp = st(0, 0);
        if (got !== exp || ack_m !== 1'b0) begin errors++; $display("FAIL slip_pause2 got=%h ack=%b exp=%h ack=0", got, ack_m, exp); end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (ack_m !== 1'b0) begin errors++; $display("FAIL slip_en0 ack=%b exp=0", ack_m); end
        en = 1'b1;
        @(negedge clk);
        checks++; got = {cnt_m, 1'b0, ph_m, ps_m, hv_m, off_m}; exp = st(0, 0);
        if (got !== exp || ack_m !== 1'b1) begin errors++; $display("FAIL slip_again got=%h ack=%b exp=%h ack=1", got, ack_m, exp); end
        slip = 1'b0;
        @(negedge clk);
    endtask
`endif

    // Async reset mid-sequence (and mid-holdoff when slip exists).
    task automatic test_reset_mid;
        en = 1'b1; load = 1'b1; load_count = 6'd17;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        checks++; got = {cnt_m, 1'b0, ph_m, ps_m, hv_m, off_m}; exp = st(17, 1);
        if (got !== exp) begin errors++; $display("FAIL pre_reset got=%h exp=%h", got, exp); end
`ifdef GEARBOX_SEQ_SLIP_EN
        slip = 1'b1;
`endif
        @(posedge clk);
        #1;
`ifdef GEARBOX_SEQ_SLIP_EN
        slip = 1'b0;
`endif
        #2 reset = 1'b0;
        #1;
        checks++; got = {cnt_m, 1'b0, ph_m, ps_m, hv_m, off_m}; exp = st(0, 0);
        if (got !== exp) begin errors++; $display("FAIL async_reset got=%h exp=%h", got, exp); end
`ifdef GEARBOX_SEQ_SLIP_EN
        checks++;
        if (ack_m !== 1'b0) begin errors++; $display("FAIL async_reset_ack got=%b exp=0", ack_m); end
`endif
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; got = {cnt_m, 1'b0, ph_m, ps_m, hv_m, off_m}; exp = st(0, 1);
        if (got !== exp) begin errors++; $display("FAIL restart0 got=%h exp=%h", got, exp); end
        @(negedge clk);
        checks++; got = {cnt_m, 1'b0, ph_m, ps_m, hv_m, off_m}; exp = st(1, 0);
        if (got !== exp) begin errors++; $display("FAIL restart1 got=%h exp=%h", got, exp); end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; load = 1'b0; load_count = '0;
        ld_aux = 1'b0; lc_aux = '0;
`ifdef GEARBOX_SEQ_SLIP_EN
        slip = 1'b0;
`endif
        test_reset;
        test_free_run;
        test_enable_toggle;
        test_load;
`ifdef GEARBOX_SEQ_SLIP_EN
        test_slip;
`endif
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gearbox_phase_seq.md
# gearbox_phase_seq

Parametrised gearbox sequencer for the 64b/66b-style PCS gearboxes, TX and RX. It drives the word phase, block count, pause and accumulated header-bit offset consumed by the gearbox datapath. It derives its cadence from datapath width, block width and header width instead of fixed constants. It adds clock-enable, synchronous count load and an optional RX alignment slip with holdoff.

## Interface
- DATA_WIDTH, 32: gearbox datapath word width in bits.
- BLOCK_WIDTH, 64: payload bits per block. Must be a multiple of DATA_WIDTH.
- HDR_WIDTH, 2: sync-header bits per block. Must divide BLOCK_WIDTH.
- SLIP_HOLDOFF, 4: enabled cycles after an accepted slip during which further slips are ignored. Must be ≥1.
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  clock enable. State advances only on cycles with en=1.
- load  in  1  synchronous load strobe.
- load_count  in  CW  value loaded into count. Values above MAX_VAL saturate to MAX_VAL.
- slip  in  1  alignment slip request pulse (only with the macro).
- slip_ack  out  1  one-cycle pulse when a slip is accepted.
- count  out  CW  block index, 0..MAX_VAL.
- phase  out  PW  word index within the block, 0..STEP_DIV-1.
- pause  out  1  high while count==MAX_VAL.
- hdr_valid  out  1  high when phase==0 and pause=0 (header word).
- bit_offset  out  OW  count*HDR_WIDTH.
- Derived widths and constants: STEP_DIV=BLOCK_WIDTH/DATA_WIDTH; MAX_VAL=BLOCK_WIDTH/HDR_WIDTH; CW=$clog2(MAX_VAL+1); PW=max(1,$clog2(STEP_DIV)); OW=$clog2(BLOCK_WIDTH+1).

## Operation
- Elaboration error if the divisibility rules fail or SLIP_HOLDOFF<1.
- Advance rule, on an enabled cycle with no load and no accepted slip:
  - If phase==STEP_DIV-1: phase←0, and count←(count==MAX_VAL)?0:count+1.
  - Otherwise: phase←phase+1.
- Load:
  - load=1 sets count←min(load_count,MAX_VAL) and phase←0, regardless of en.
  - Load has the highest priority. It cancels a slip requested in the same cycle, and no slip_ack is issued.
  - Load also clears the holdoff counter.
- Slip:
  - A slip is accepted when slip=1, en=1, load=0, pause=0 and the holdoff counter is 0.
  - An accepted slip holds phase and count for that cycle, delaying the sequence by one word.
  - The holdoff counter then loads SLIP_HOLDOFF and decrements on each enabled cycle.
  - Slips that arrive during pause, during holdoff or with en=0 are dropped silently.
- pause, hdr_valid and bit_offset are decoded only from the count and phase registers. There is no combinational path from any input to any output.
- With the defaults (STEP_DIV=2, MAX_VAL=32), one sequence is 66 enabled cycles, and pause is high for the last 2 of them.

## Timing
- Reset values: count=0, phase=0, pause=0, hdr_valid=1, bit_offset=0, slip_ack=0, holdoff counter 0.
- Reset deassertion is synchronised externally. The first advance happens on the first enabled edge after release.
- count and phase update one cycle after the enabled edge. Decoded outputs follow in the same cycle, with zero extra latency.
- slip_ack is registered and is high in the cycle after acceptance.
- Wrap: count goes MAX_VAL→0 only at phase STEP_DIV-1. pause and bit_offset=BLOCK_WIDTH hold for exactly STEP_DIV enabled cycles.
- With en=0, all state holds and outputs are stable, except that load still applies.
- Reset asserted mid-sequence or mid-holdoff returns everything to the reset values immediately, asynchronously.

## Configuration
- GEARBOX_SEQ_SLIP_EN defined: the slip port, slip_ack and the holdoff logic exist as described.
- Undefined: the slip and slip_ack ports are absent, SLIP_HOLDOFF is ignored, and the sequence advances on every enabled cycle.

## Structure
- Shared gearbox_pkg holds:
  - functions computing STEP_DIV, MAX_VAL, CW, PW and OW from the parameters, shared with the gearbox datapaths;
  - the default 64b/66b width constants.
- One natural sub-module, gearbox_slip_ctl: the acceptance qualifier, holdoff counter and slip_ack register. It is instantiated only under GEARBOX_SEQ_SLIP_EN.

## Test plan
- Defaults, en=1 for 132 cycles after reset → count 0..32 each held 2 cycles; pause high in cycles 64–65 and 130–131; bit_offset=64 during pause; wrap to 0.
- DATA_WIDTH=64 → STEP_DIV=1, phase constantly 0, pause for 1 cycle every 33. DATA_WIDTH=16 → phase 0..3, pause 4 cycles.
- Toggle en every other cycle → sequence identical to the free-running case, stretched ×2; outputs stable while en=0.
- load=1 with load_count=40 at count 5, phase 1 → next cycle count=32, phase 0, pause=1. Simultaneous slip is not acked.
- With the macro defined: slip at count 3 phase 0 → slip_ack next cycle, state held one cycle. A second slip 2 cycles later is ignored. A slip during pause is ignored.
- Assert reset at count 17 → all outputs at reset values without a clock edge; the sequence restarts at 0.
